// File: rtl/regfile_sb_pkg.sv
// Shared types and default sizes for the scoreboarded register file.
package regfile_sb_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int DEF_XLEN  = 32;
    localparam int DEF_NREGS = 32;

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Pending-producer bits with set/clear and NRD parallel lookups.
module regfile_sb_scoreboard
    import regfile_sb_pkg::*;
#(
    parameter int NREGS = DEF_NREGS,
    parameter int NRD   = 2,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              set_en,
    input  logic [AW-1:0]     set_addr,
    input  logic              clr_en,
    input  logic [AW-1:0]     clr_addr,
    input  logic [NRD*AW-1:0] raddr,
    output logic [NRD-1:0]    busy
);

    logic [NREGS-1:0] pending_q, pending_d;

    // Set is applied after clear so a same-cycle new producer keeps the bit.
    always_comb begin
        pending_d = pending_q;
        if (clr_en) pending_d[clr_addr] = 1'b0;
        if (set_en) pending_d[set_addr] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pending_q <= '0;
        else        pending_q <= pending_d;
    end

    always_comb begin
        busy = '0;
        for (int i = 0; i < NRD; i++)
            busy[i] = pending_q[raddr[i*AW +: AW]];
    end

endmodule

// File: rtl/regfile_sb.sv
// Register file with clear-on-reset sequencer and producer scoreboard.
// Define REGFILE_SB_BYPASS_EN to forward same-cycle writes to the read ports.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int XLEN  = DEF_XLEN,
    parameter int NREGS = DEF_NREGS,
    parameter int NRD   = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       we,
    input  logic [$clog2(NREGS)-1:0]   waddr,
    input  logic [XLEN-1:0]            wdata,
    input  logic [NRD*$clog2(NREGS)-1:0] raddr,
    output logic [NRD*XLEN-1:0]        rdata,
    output logic [NRD-1:0]             rbusy,
    input  logic                       rsv_valid,
    input  logic [$clog2(NREGS)-1:0]   rsv_addr,
    output logic                       init_done
);

    localparam int AW = $clog2(NREGS);

    state_e          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic            run;

    logic            wr_en;
    logic [AW-1:0]   wr_idx;
    logic [XLEN-1:0] wr_data;
    logic [XLEN-1:0] regs_q [NREGS];

    logic            sb_set, sb_clr;
    logic [NRD-1:0]  sb_busy;

    assign run       = (state_q == ST_RUN);
    assign init_done = run;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_INIT) begin
            if (cnt_q == AW'(NREGS - 1)) state_d = ST_RUN;
            else                         cnt_d   = cnt_q + AW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            cnt_q   <= AW'(1);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // One write port shared by the clear sequencer and write-back.
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = waddr;
        wr_data = wdata;
        if (!run) begin
            wr_en   = 1'b1;
            wr_idx  = cnt_q;
            wr_data = '0;
        end else if (we && waddr != '0) begin
            wr_en = 1'b1;
        end
    end

    // Contents are deliberately not reset; the INIT sweep clears them.
    always_ff @(posedge clk) begin
        if (wr_en) regs_q[wr_idx] <= wr_data;
    end

    assign sb_set = run && rsv_valid && (rsv_addr != '0);
    assign sb_clr = run && we && (waddr != '0);

    regfile_sb_scoreboard #(
        .NREGS (NREGS),
        .NRD   (NRD),
        .AW    (AW)
    ) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (sb_set),
        .set_addr (rsv_addr),
        .clr_en   (sb_clr),
        .clr_addr (waddr),
        .raddr    (raddr),
        .busy     (sb_busy)
    );

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] ra;
        assign ra = raddr[i*AW +: AW];

        always_comb begin
            rdata[i*XLEN +: XLEN] = '0;
            rbusy[i]              = 1'b0;
            if (run && ra != '0) begin
                rdata[i*XLEN +: XLEN] = regs_q[ra];
                rbusy[i]              = sb_busy[i];
`ifdef REGFILE_SB_BYPASS_EN
                if (we && waddr == ra) begin
                    rdata[i*XLEN +: XLEN] = wdata;
                    rbusy[i]              = 1'b0;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb with default parameters.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic [1:0]  rbusy;
    logic        rsv_valid;
    logic [4:0]  rsv_addr;
    logic        init_done;

    int n_vec = 0;
    int n_bad = 0;

    regfile_sb dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .raddr     (raddr),
        .rdata     (rdata),
        .rbusy     (rbusy),
        .rsv_valid (rsv_valid),
        .rsv_addr  (rsv_addr),
        .init_done (init_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
        raddr = {a1, a0};
    endtask

    // Inputs change on the falling edge; one rising edge per call.
    task automatic step;
        @(negedge clk);
        we = 1'b0;
        rsv_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
        raddr = '0; rsv_valid = 1'b0; rsv_addr = '0;
        repeat (3) @(negedge clk);
        rd(5'd5, 5'd31);
        #1;
        chk("rst_init_done", 32'(init_done), 32'd0);
        chk("rst_rbusy", 32'(rbusy), 32'd0);
        chk("rst_rdata0", rdata[31:0], 32'd0);

        // Release at a falling edge: INIT spans 31 rising edges.
        rst_n = 1'b1;
        #1 chk("init_k0", 32'(init_done), 32'd0);
        for (int k = 1; k <= 31; k++) begin
            @(negedge clk); #1;
            chk($sformatf("init_k%0d", k), 32'(init_done), (k == 31) ? 32'd1 : 32'd0);
        end
        for (int r = 0; r < 32; r++) begin
            rd(5'(r), 5'(31 - r)); #1;
            chk($sformatf("clr_r%0d", r), rdata[31:0], 32'd0);
            chk($sformatf("clr_b%0d", r), 32'(rbusy), 32'd0);
        end

        // Basic write then read, port 1 at x0.
        we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
        step();
        rd(5'd5, 5'd0); #1;
        chk("wr_x5", rdata[31:0], 32'hDEADBEEF);
        chk("rd_x0", rdata[63:32], 32'h0);

        // Writes and reserves to x0 are dropped.
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF;
        rsv_valid = 1'b1; rsv_addr = 5'd0;
        step();
        rd(5'd0, 5'd0); #1;
        chk("x0_data", rdata[31:0], 32'h0);
        chk("x0_busy", 32'(rbusy), 32'd0);

        // Reserve x7, then write-back clears it.
        rsv_valid = 1'b1; rsv_addr = 5'd7;
        step();
        rd(5'd7, 5'd0); #1;
        chk("rsv_x7_busy", 32'(rbusy), 32'b01);
        we = 1'b1; waddr = 5'd7; wdata = 32'h12;
        step();
        #1;
        chk("wb_x7_busy", 32'(rbusy[0]), 32'd0);
        chk("wb_x7_data", rdata[31:0], 32'h12);

        // Same-cycle reserve and write: data lands, pending stays set.
        we = 1'b1; waddr = 5'd9; wdata = 32'h55;
        rsv_valid = 1'b1; rsv_addr = 5'd9;
        step();
        rd(5'd9, 5'd9); #1;
        chk("both_x9_d0", rdata[31:0], 32'h55);
        chk("both_x9_d1", rdata[63:32], 32'h55);
        chk("both_x9_busy", 32'(rbusy), 32'b11);

        // Read x3 during its own write-back.
        we = 1'b1; waddr = 5'd3; wdata = 32'h11111111;
        step();
        rsv_valid = 1'b1; rsv_addr = 5'd3;
        step();
        rd(5'd3, 5'd5);
        we = 1'b1; waddr = 5'd3; wdata = 32'hA5A5A5A5;
        #1;
`ifdef REGFILE_SB_BYPASS_EN
        chk("byp_x3_data", rdata[31:0], 32'hA5A5A5A5);
        chk("byp_x3_busy", 32'(rbusy[0]), 32'd0);
`else
        chk("nobyp_x3_data", rdata[31:0], 32'h11111111);
        chk("nobyp_x3_busy", 32'(rbusy[0]), 32'd1);
`endif
        chk("byp_other_port", rdata[63:32], 32'hDEADBEEF);
        step();
        #1;
        chk("post_x3_data", rdata[31:0], 32'hA5A5A5A5);
        chk("post_x3_busy", 32'(rbusy[0]), 32'd0);

        // Reset mid-RUN with x4 pending.
        we = 1'b1; waddr = 5'd4; wdata = 32'h44;
        step();
        rsv_valid = 1'b1; rsv_addr = 5'd4;
        step();
        rd(5'd4, 5'd5); #1;
        chk("x4_pre_data", rdata[31:0], 32'h44);
        chk("x4_pre_busy", 32'(rbusy), 32'b01);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_init_done", 32'(init_done), 32'd0);
        chk("mid_rst_rdata", rdata[31:0], 32'd0);
        chk("mid_rst_rbusy", 32'(rbusy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        // Reserves during INIT must be ignored.
        rsv_valid = 1'b1; rsv_addr = 5'd4;
        repeat (30) @(negedge clk);
        #1 chk("reinit_k30", 32'(init_done), 32'd0);
        @(negedge clk);
        rsv_valid = 1'b0;
        #1;
        chk("reinit_done", 32'(init_done), 32'd1);
        chk("reinit_x4_data", rdata[31:0], 32'd0);
        chk("reinit_x5_data", rdata[63:32], 32'd0);
        chk("reinit_busy", 32'(rbusy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 SHALL have parameter NREGS, default 32, register count, power of two in 4..64.
REQ-003 SHALL have parameter NRD, default 2, number of read ports, 1..4.
REQ-004 SHALL derive local AW = log2(NREGS) for all address fields.
REQ-005 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have port we  in  1  write-back enable.
REQ-008 SHALL have port waddr  in  AW  write-back register index.
REQ-009 SHALL have port wdata  in  XLEN  write-back data.
REQ-010 SHALL have port raddr  in  NRD*AW  read indices, port i at bits [i*AW +: AW].
REQ-011 SHALL have port rdata  out  NRD*XLEN  read data, port i at [i*XLEN +: XLEN].
REQ-012 SHALL have port rbusy  out  NRD  port i source has an outstanding producer.
REQ-013 SHALL have port rsv_valid  in  1  reserve request, marks a destination pending.
REQ-014 SHALL have port rsv_addr  in  AW  register to reserve.
REQ-015 SHALL have port init_done  out  1  clear sequence finished, block usable.

Function
REQ-016 SHALL implement a two-state FSM: INIT, clearing one register per cycle, then RUN.
REQ-017 In INIT, the block SHALL write 0 to index cnt, starting at cnt=1 and incrementing to NREGS-1, then enter RUN; INIT lasts NREGS-1 cycles.
REQ-018 In INIT, the block SHALL hold init_done=0, ignore we and rsv_valid, force rdata=0, and force rbusy=0.
REQ-019 In RUN, init_done SHALL be 1, and we with waddr!=0 SHALL write wdata on the rising edge.
REQ-020 Index 0 SHALL always read 0 and never be pending; writes and reserves to index 0 SHALL be ignored.
REQ-021 Reads SHALL be combinational, so rdata[i] equals the stored regs[raddr[i]] with zero latency.
REQ-022 The scoreboard SHALL hold pending[NREGS]; rsv_valid sets pending[rsv_addr], and we clears pending[waddr], both in RUN.
REQ-023 If rsv_valid and we target the same nonzero index in the same cycle, the data SHALL be written and pending SHALL end set, because the new producer wins.
REQ-024 rbusy[i] SHALL equal pending[raddr[i]] as registered, except as modified by REQ-026.
REQ-025 Multiple read ports with the same address SHALL return identical data and busy values.

Reset
REQ-026 With REGFILE_SB_BYPASS_EN defined, a same-cycle write (we, waddr==raddr[i]!=0, RUN) SHALL forward wdata to rdata[i] and force rbusy[i]=0.
REQ-027 rst_n low SHALL immediately set FSM=INIT, cnt=1, all pending=0, and init_done=0; regs contents are not reset directly.
REQ-028 Reset asserted mid-INIT or mid-RUN SHALL restart the full clear sequence after release; partial state SHALL be discarded.
REQ-029 After rst_n rises, the first clear write SHALL occur on the first rising clk edge.

Configuration
REQ-030 Macro REGFILE_SB_BYPASS_EN SHALL enable write-to-read forwarding per REQ-026.
REQ-031 Without REGFILE_SB_BYPASS_EN, reads SHALL return the pre-edge array value, rbusy SHALL reflect the registered pending bits, and no forwarding mux SHALL exist.

Structure
REQ-032 A shared package SHALL hold the FSM state enum (ST_INIT, ST_RUN) and the default XLEN/NREGS constants.
REQ-033 The scoreboard SHALL be a sub-module regfile_sb_scoreboard (pending bits, set/clear, NRD lookups); storage, FSM, and read muxing SHALL stay in the top module.

Verification
REQ-034 The bench SHALL release reset with defaults: init_done=0 for 31 cycles then 1, and all raddr reads return 0x00000000.
REQ-035 The bench SHALL, in RUN, write x5=0xDEADBEEF, then read raddr0=5 and raddr1=0 on the next cycle, expecting 0xDEADBEEF and 0x0.
REQ-036 The bench SHALL reserve x7 and read x7, expecting rbusy0=1; a write of 0x12 to x7 clears it, and the next cycle gives rbusy0=0 and rdata=0x12.
REQ-037 The bench SHALL issue a simultaneous rsv and we on x9=0x55, expecting the next cycle rdata=0x55 and rbusy=1.
REQ-038 The bench SHALL, with REGFILE_SB_BYPASS_EN, write x3=0xA5A5A5A5 while reading x3 in the same cycle, expecting rdata=0xA5A5A5A5 and rbusy=0; without the macro, the old value is returned.
REQ-039 The bench SHALL assert rst_n low mid-RUN with x4 pending, expecting pending cleared, init_done=0 at once, and x4 reading 0 after the re-clear.
